// File: rtl/lenet_mac_requant_if.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_mac_requant_if
//  Description : Streaming bus for the LeNet accumulate/requantize stage.
//                Carries the product tap stream from the multiplier, the
//                per-window bias, and the requantized activation stream to
//                the pooling/line-buffer stage.
//  Signals     : prod_data/prod_valid/prod_last/prod_ready - tap stream
//                bias                                      - window bias
//                out_data/out_valid/out_ready              - activation stream
//  Modports    : slave  - the accumulate/requantize stage
//                master - the surrounding datapath (producer + consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lenet_mac_requant_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  prod_data;
    logic                 prod_valid;
    logic                 prod_last;
    logic                 prod_ready;
    logic [31:0]          bias;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  prod_data, prod_valid, prod_last, bias, out_ready,
        output prod_ready, out_data, out_valid
    );

    modport master (
        output prod_data, prod_valid, prod_last, bias, out_ready,
        input  prod_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/lenet_mac_requant.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_mac_requant
//  Description : Sums TAPS signed products plus a bias, then rounds
//                (half-up), arithmetic-shifts by SHIFT, optionally applies
//                ReLU and saturates to a signed OUT_WIDTH activation, which
//                is offered on a valid/ready handshake.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous assert, active-low reset
//                mac_if     - tap stream in, activation stream out (slave)
//                err_last_o - sticky framing error (prod_last disagreed with
//                             the tap counter on some accepted tap)
//  Revision    : 1.0 - initial release
// ============================================================================
module lenet_mac_requant #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 48,
    parameter int TAPS      = 25,
    parameter int SHIFT     = 14,
    parameter int OUT_WIDTH = 16,
    parameter int RELU      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lenet_mac_requant_if.slave   mac_if,
    output logic                 err_last_o
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] c_last_tap = CNT_W'(TAPS - 1);

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [ACC_WIDTH-1:0] c_round =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);

    // Output range limits expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] c_out_max =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_out_min =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                        state_q,     state_d;
    logic [CNT_W-1:0]              tap_cnt_q,   tap_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q,       acc_d;
    logic [OUT_WIDTH-1:0]          out_data_q,  out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          err_q,       err_d;

    logic                          w_accept;
    logic                          w_is_last;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_bias_ext;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic signed [ACC_WIDTH-1:0]   w_relu;
    logic [OUT_WIDTH-1:0]          w_sat;

    // Ready is also gated by reset so the upstream multiplier is stalled
    // for as long as reset is held.
    assign mac_if.prod_ready = rst_n & (state_q == ST_ACCUM);
    assign mac_if.out_data   = out_data_q;
    assign mac_if.out_valid  = out_valid_q;
    assign err_last_o        = err_q;

    assign w_accept   = mac_if.prod_valid & mac_if.prod_ready;
    assign w_is_last  = (tap_cnt_q == c_last_tap);
    assign w_prod_ext = {{(ACC_WIDTH-IN_WIDTH){mac_if.prod_data[IN_WIDTH-1]}},
                         mac_if.prod_data};
    assign w_bias_ext = {{(ACC_WIDTH-32){mac_if.bias[31]}}, mac_if.bias};

    // Full-precision round then arithmetic shift; both operands are signed.
    assign w_shifted = (acc_q + c_round) >>> SHIFT;

    generate
        if (RELU != 0) begin : g_relu
            assign w_relu = w_shifted[ACC_WIDTH-1] ? '0 : w_shifted;
        end else begin : g_no_relu
            assign w_relu = w_shifted;
        end
    endgenerate

    always_comb begin
        w_sat = w_relu[OUT_WIDTH-1:0];
        if (w_relu > c_out_max) begin
            w_sat = c_out_max[OUT_WIDTH-1:0];
        end else if (w_relu < c_out_min) begin
            w_sat = c_out_min[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    // The first tap of a window restarts from the bias.
                    if (tap_cnt_q == '0) begin
                        acc_d = w_bias_ext + w_prod_ext;
                    end else begin
                        acc_d = acc_q + w_prod_ext;
                    end
                    // prod_last is only cross-checked; the counter alone
                    // decides where a window ends.
                    if (mac_if.prod_last != w_is_last) begin
                        err_d = 1'b1;
                    end
                    if (w_is_last) begin
                        tap_cnt_d = '0;
                        state_d   = ST_ROUND;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ROUND: begin
                out_data_d  = w_sat;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && mac_if.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

endmodule
`default_nettype wire
